// File: rtl/tone_synth_pkg.sv
// Shared types and constants for the tone synthesiser: phase enumeration,
// default widths and the volume-to-duty thresholds used by the PWM gate.
package tone_synth_pkg;

    localparam int TONE_W_DEF = 24;
    localparam int VOL_W_DEF  = 2;
    localparam int PWM_W      = 3;

    // Duty thresholds in eighths of the PWM period; the last one is a full square wave.
    localparam logic [PWM_W:0] PWM_THR_VOL0 = 4'd1;
    localparam logic [PWM_W:0] PWM_THR_VOL1 = 4'd2;
    localparam logic [PWM_W:0] PWM_THR_VOL2 = 4'd4;
    localparam logic [PWM_W:0] PWM_THR_VOL3 = 4'd8;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2
    } synth_state_e;

endpackage

// File: rtl/tone_synth_pwm_gate.sv
// Volume gate: passes the high phase only while the free-running PWM count
// is below the duty threshold selected by volume.
module pwm_gate
    import tone_synth_pkg::*;
#(
    parameter int VOL_W = VOL_W_DEF
) (
    input  logic [VOL_W-1:0] volume,
    input  logic             high_phase,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             gated
);

    logic [PWM_W:0] w_thr;

    always_comb begin
        w_thr = PWM_THR_VOL3;
        if (volume == VOL_W'(0)) begin
            w_thr = PWM_THR_VOL0;
        end else if (volume == VOL_W'(1)) begin
            w_thr = PWM_THR_VOL1;
        end else if (volume == VOL_W'(2)) begin
            w_thr = PWM_THR_VOL2;
        end
    end

    assign gated = high_phase && ({1'b0, pwm_cnt} < w_thr);

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator with glitch-free tone changes at half-period
// boundaries, a pending-tone buffer and a PWM volume gate.
//
// state  | meaning
// SILENT | no tone playing; waiting for a pending tone or re-enable
// HIGH   | high half-period of the square wave (PWM gated by volume)
// LOW    | low half-period; output held at 0
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter int TONE_W = TONE_W_DEF,
    parameter int VOL_W  = VOL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TONE_W-1:0] tone,
    input  logic              tone_valid,
    input  logic              enable,
    input  logic [VOL_W-1:0]  volume,
    output logic              wave_out,
    output logic [TONE_W-1:0] active_tone,
    output logic              note_edge,
    output logic              busy
);

    synth_state_e      r_state;
    logic [TONE_W-1:0] r_cnt;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [TONE_W-1:0] r_pending;
    logic              r_pending_valid;
    logic [TONE_W-1:0] r_active_tone;
    logic              r_wave;
    logic              r_note_edge;

    synth_state_e      w_state_nx;
    logic [TONE_W-1:0] w_cnt_nx;
    logic [TONE_W-1:0] w_active_nx;
    logic [PWM_W-1:0]  w_pwm_nx;
    logic              w_apply;
    logic              w_pend_valid;
    logic [TONE_W-1:0] w_pend_tone;
    logic              w_boundary;
    logic              w_wave_nx;

    // A strobe in the same cycle as an application point is seen immediately.
    assign w_pend_valid = tone_valid | r_pending_valid;
    assign w_pend_tone  = tone_valid ? tone : r_pending;
    assign w_boundary   = (r_cnt == r_active_tone - TONE_W'(1));

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_active_nx = r_active_tone;
        w_apply     = 1'b0;
        if (!enable) begin
            w_state_nx = SILENT;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                SILENT: begin
                    w_cnt_nx = '0;
                    if (w_pend_valid) begin
                        w_apply     = 1'b1;
                        w_active_nx = w_pend_tone;
                        w_state_nx  = (w_pend_tone == '0) ? SILENT : HIGH;
                    end else if (r_active_tone != '0) begin
                        w_state_nx = HIGH;
                    end
                end
                HIGH, LOW: begin
                    if (w_boundary) begin
                        w_cnt_nx = '0;
                        if (w_pend_valid) begin
                            w_apply     = 1'b1;
                            w_active_nx = w_pend_tone;
                        end
                        if (w_pend_valid && (w_pend_tone == '0)) begin
                            w_state_nx = SILENT;
                        end else begin
                            w_state_nx = (r_state == HIGH) ? LOW : HIGH;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + TONE_W'(1);
                    end
                end
                default: begin
                    w_state_nx = SILENT;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // PWM restarts from 0 on the first cycle after leaving SILENT.
    assign w_pwm_nx = (r_state == SILENT) ? '0 : r_pwm_cnt + PWM_W'(1);

    pwm_gate #(
        .VOL_W (VOL_W)
    ) u_pwm_gate (
        .volume     (volume),
        .high_phase (w_state_nx == HIGH),
        .pwm_cnt    (w_pwm_nx),
        .gated      (w_wave_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= SILENT;
            r_cnt           <= '0;
            r_pwm_cnt       <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_active_tone   <= '0;
            r_wave          <= 1'b0;
            r_note_edge     <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_cnt           <= w_cnt_nx;
            r_pwm_cnt       <= w_pwm_nx;
            r_pending       <= w_pend_tone;
            r_pending_valid <= w_apply ? 1'b0 : w_pend_valid;
            r_active_tone   <= w_active_nx;
            r_wave          <= w_wave_nx;
            r_note_edge     <= w_apply;
        end
    end

    assign wave_out    = r_wave;
    assign active_tone = r_active_tone;
    assign note_edge   = r_note_edge;
    assign busy        = r_pending_valid;

endmodule
